// File: rtl/and_operand_gen.sv
// Synthesizable operand sweeper for basic_and. It walks every {a,b} pair and holds each one for dwell+1 cycles.
// Define AND_GEN_LFSR_EN to enable the LFSR sweep selected by mode=1. In the default build, mode is ignored.
module and_operand_gen #(
  parameter int WIDTH   = 4,
  parameter int DWELL_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               pause,
  input  logic               mode,
  input  logic [DWELL_W-1:0] dwell,
  output logic [WIDTH-1:0]   a,
  output logic [WIDTH-1:0]   b,
  output logic               valid,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH:0]   pair_count
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] COUNT_FULL = CW'(1) << PW;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  logic [PW-1:0]      pair;
  logic [DWELL_W-1:0] timer;
  logic [DWELL_W-1:0] dwell_q;
  logic               lfsr_q;
  logic [PW-1:0]      first_pair;
  logic [PW-1:0]      next_pair;
  logic [CW-1:0]      last_count;

`ifdef AND_GEN_LFSR_EN
  // Right-shifting Galois masks for x^8+x^6+x^5+x^4+1 and x^16+x^14+x^13+x^11+1.
  localparam logic [PW-1:0] TAPS = (PW == 8) ? PW'(8'hB8) : PW'(16'hB400);

  always_comb begin
    first_pair = mode ? PW'(1) : '0;
    next_pair  = lfsr_q ? ((pair >> 1) ^ (pair[0] ? TAPS : '0)) : pair + 1'b1;
    last_count = lfsr_q ? COUNT_FULL - 1'b1 : COUNT_FULL;
  end
`else
  logic unused_mode;
  assign unused_mode = mode;

  always_comb begin
    first_pair = '0;
    next_pair  = pair + 1'b1;
    last_count = COUNT_FULL;
  end
`endif

  assign a = pair[PW-1:WIDTH];
  assign b = pair[WIDTH-1:0];

  // NOTE: State registers use non-blocking assignment, so every branch reads the values from before the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      pair       <= '0;
      timer      <= '0;
      dwell_q    <= '0;
      lfsr_q     <= 1'b0;
      pair_count <= '0;
      valid      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state      <= RUN;
            pair       <= first_pair;
            timer      <= '0;
            dwell_q    <= dwell;
`ifdef AND_GEN_LFSR_EN
            lfsr_q     <= mode;
`else
            lfsr_q     <= 1'b0;
`endif
            pair_count <= CW'(1);
            valid      <= 1'b1;
            busy       <= 1'b1;
            done       <= 1'b0;
          end
        end
        RUN: begin
          // Pause takes priority over the terminal count, so a pair never advances while paused.
          if (pause) begin
            valid <= 1'b0;
          end else begin
            valid <= 1'b1;
            if (timer == dwell_q) begin
              if (pair_count == last_count) begin
                state <= DONE;
                valid <= 1'b0;
                busy  <= 1'b0;
                done  <= 1'b1;
              end else begin
                pair       <= next_pair;
                timer      <= '0;
                pair_count <= pair_count + 1'b1;
              end
            end else begin
              timer <= timer + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_and_operand_gen.sv
// Self-checking bench for and_operand_gen (WIDTH=4). It uses a vector table, directed corner sequences,
// and a randomized run that is checked against a pair/hold reference model.
module tb_and_operand_gen;

  localparam int WIDTH   = 4;
  localparam int DWELL_W = 16;
  localparam int NPAIRS  = 256;

  logic               clk = 1'b0;
  logic               rst, start, pause, mode;
  logic [DWELL_W-1:0] dwell;
  logic [WIDTH-1:0]   a, b;
  logic               valid, busy, done;
  logic [2*WIDTH:0]   pair_count;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  and_operand_gen #(.WIDTH(WIDTH), .DWELL_W(DWELL_W)) dut (
    .clk(clk), .rst(rst), .start(start), .pause(pause), .mode(mode), .dwell(dwell),
    .a(a), .b(b), .valid(valid), .busy(busy), .done(done), .pair_count(pair_count)
  );

  typedef struct {
    logic        r, s, p;
    logic [15:0] dw;
    logic [7:0]  pair;
    logic        v, bz, d;
    logic [8:0]  cnt;
  } vec_t;

  vec_t vecs[12];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] pk(input logic [7:0] pair, input logic v, input logic bz,
                                     input logic d, input logic [8:0] cnt);
    return 64'({pair, v, bz, d, cnt});
  endfunction

  function automatic logic [63:0] obs();
    return 64'({a, b, valid, busy, done, pair_count});
  endfunction

  // Reference model: sweep position, cycles spent on the current pair, and phase.
  int m_state, m_pair, m_cnt, m_hold, m_dw;
  bit m_valid;

  task automatic model_step(input bit r, input bit s, input bit p, input int dw);
    if (r) begin
      m_state = 0; m_pair = 0; m_cnt = 0; m_valid = 0;
    end else if (m_state != 1) begin
      if (s) begin
        m_state = 1; m_pair = 0; m_hold = 0; m_dw = dw; m_cnt = 1; m_valid = 1;
      end
    end else if (p) begin
      m_valid = 0;
    end else begin
      m_valid = 1;
      m_hold++;
      if (m_hold > m_dw) begin
        if (m_cnt == NPAIRS) begin
          m_state = 2; m_valid = 0;
        end else begin
          m_pair++; m_cnt++; m_hold = 0;
        end
      end
    end
  endtask

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; pause = 1'b0; mode = 1'b0; dwell = '0;

    // Table: dwell=1 sweep start, ignored dwell change and start, pause over terminal count, rst+start.
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 16'd1, 8'h00, 1'b0, 1'b0, 1'b0, 9'd0};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 16'd1, 8'h00, 1'b0, 1'b0, 1'b0, 9'd0};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 16'd1, 8'h00, 1'b1, 1'b1, 1'b0, 9'd1};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 16'd5, 8'h00, 1'b1, 1'b1, 1'b0, 9'd1};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 16'd5, 8'h01, 1'b1, 1'b1, 1'b0, 9'd2};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 16'd5, 8'h01, 1'b1, 1'b1, 1'b0, 9'd2};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 16'd5, 8'h01, 1'b0, 1'b1, 1'b0, 9'd2};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 16'd5, 8'h01, 1'b0, 1'b1, 1'b0, 9'd2};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 16'd5, 8'h02, 1'b1, 1'b1, 1'b0, 9'd3};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 16'd5, 8'h02, 1'b1, 1'b1, 1'b0, 9'd3};
    vecs[10] = '{1'b1, 1'b1, 1'b0, 16'd5, 8'h00, 1'b0, 1'b0, 1'b0, 9'd0};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 16'd5, 8'h00, 1'b0, 1'b0, 1'b0, 9'd0};

    for (int i = 0; i < 12; i++) begin
      rst = vecs[i].r; start = vecs[i].s; pause = vecs[i].p; dwell = vecs[i].dw;
      tick();
      check($sformatf("vec%0d", i), obs(),
            pk(vecs[i].pair, vecs[i].v, vecs[i].bz, vecs[i].d, vecs[i].cnt));
    end
    rst = 1'b0; start = 1'b0; pause = 1'b0;

    // Full dwell=0 sweep: one new pair per cycle, then DONE with count 256.
    rst = 1'b1; tick(); rst = 1'b0;
    dwell = 16'd0; start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < NPAIRS; i++) begin
      check($sformatf("sweep%0d", i), obs(), pk(8'(i), 1'b1, 1'b1, 1'b0, 9'(i + 1)));
      tick();
    end
    check("sweep_done", obs(), pk(8'hFF, 1'b0, 1'b0, 1'b1, 9'd256));
    tick();
    check("done_held", obs(), pk(8'hFF, 1'b0, 1'b0, 1'b1, 9'd256));

    // Restart from DONE with dwell=19: each pair is held for 20 cycles.
    dwell = 16'd19; start = 1'b1; tick(); start = 1'b0;
    check("restart", obs(), pk(8'h00, 1'b1, 1'b1, 1'b0, 9'd1));
    for (int j = 1; j < 20; j++) begin
      tick();
      check($sformatf("dwell_p0_%0d", j), obs(), pk(8'h00, 1'b1, 1'b1, 1'b0, 9'd1));
    end
    tick();
    check("dwell_step", obs(), pk(8'h01, 1'b1, 1'b1, 1'b0, 9'd2));
    start = 1'b1; dwell = 16'd0; tick(); start = 1'b0;
    check("start_in_run", obs(), pk(8'h01, 1'b1, 1'b1, 1'b0, 9'd2));
    for (int j = 2; j < 20; j++) tick();
    check("dwell_p1_end", obs(), pk(8'h01, 1'b1, 1'b1, 1'b0, 9'd2));
    tick();
    check("dwell_p2", obs(), pk(8'h02, 1'b1, 1'b1, 1'b0, 9'd3));

    // Pause at pair (3,5) with timer=7 (pair 53, 1067 cycles after start).
    rst = 1'b1; tick(); rst = 1'b0;
    dwell = 16'd19; start = 1'b1; tick(); start = 1'b0;
    repeat (1067) tick();
    check("pause_pre", obs(), pk(8'h35, 1'b1, 1'b1, 1'b0, 9'd54));
    pause = 1'b1;
    for (int j = 0; j < 5; j++) begin
      tick();
      check($sformatf("paused%0d", j), obs(), pk(8'h35, 1'b0, 1'b1, 1'b0, 9'd54));
    end
    pause = 1'b0;
    n = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if ({a, b} != 8'h35) break;
      n++;
    end
    check("pause_hold_len", 64'(n), 64'd12);
    check("pause_next", obs(), pk(8'h36, 1'b1, 1'b1, 1'b0, 9'd55));

    // Reset during pair (7,2).
    rst = 1'b1; tick(); rst = 1'b0;
    dwell = 16'd0; start = 1'b1; tick(); start = 1'b0;
    repeat (114) tick();
    check("pre_abort", obs(), pk(8'h72, 1'b1, 1'b1, 1'b0, 9'd115));
    rst = 1'b1; tick(); rst = 1'b0;
    check("abort", obs(), pk(8'h00, 1'b0, 1'b0, 1'b0, 9'd0));
    tick();
    check("idle_after_abort", obs(), pk(8'h00, 1'b0, 1'b0, 1'b0, 9'd0));

`ifdef AND_GEN_LFSR_EN
    begin
      bit seen[256];
      bit ok;
      mode = 1'b1; dwell = 16'd0; start = 1'b1; tick(); start = 1'b0;
      check("lfsr_first", obs(), pk(8'h01, 1'b1, 1'b1, 1'b0, 9'd1));
      ok = 1'b1;
      for (int i = 0; i < 255; i++) begin
        if (!valid || {a, b} == 8'h00 || seen[{a, b}]) ok = 1'b0;
        seen[{a, b}] = 1'b1;
        tick();
      end
      check("lfsr_distinct", 64'(ok), 64'd1);
      check("lfsr_done", 64'({valid, busy, done, pair_count}), 64'({1'b0, 1'b0, 1'b1, 9'd255}));
      mode = 1'b0;
      rst = 1'b1; tick(); rst = 1'b0;
    end
`endif

    // Randomized run against the reference model.
    rst = 1'b1; pause = 1'b0; start = 1'b0;
    model_step(1'b1, 1'b0, 1'b0, 0);
    tick();
    for (int c = 0; c < 3000; c++) begin
      rst   = ($urandom_range(0, 999) == 0);
      start = (m_state == 1) ? ($urandom_range(0, 49) == 0) : ($urandom_range(0, 7) == 0);
      pause = ($urandom_range(0, 3) == 0);
      dwell = DWELL_W'($urandom_range(0, 2));
      model_step(rst, start, pause, int'(dwell));
      tick();
      check($sformatf("rand%0d", c), obs(),
            pk(8'(m_pair), m_valid, m_state == 1, m_state == 2, 9'(m_cnt)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
